// File: rtl/draw_pkg.sv
// Shared screen geometry, colour type and FSM state encoding for the drawing engine.
package draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COORD_W  = 11;

  typedef logic [2:0] colour_t;

  localparam colour_t BLACK = 3'b000;
  localparam colour_t WHITE = 3'b111;

  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

endpackage

// File: rtl/raster_counter.sv
// Nested x/y raster walker: x runs inner across the row, y steps outer.
module raster_counter
  import draw_pkg::*;
(
  input  logic               clock,
  input  logic               load,
  input  logic               advance,
  input  logic [COORD_W-1:0] org_x,
  input  logic [COORD_W-1:0] org_y,
  input  logic [COORD_W-1:0] ext_w,
  input  logic [COORD_W-1:0] ext_h,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic               last
);

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  logic [COORD_W-1:0] x_first;
  logic [COORD_W-1:0] x_last;
  logic [COORD_W-1:0] y_last;
  logic               row_end;

  assign row_end = (cx == x_last);
  assign last    = row_end && (cy == y_last);

  // Pure datapath: the owning FSM decides when these values mean anything.
  always_ff @(posedge clock) begin
    if (load) begin
      cx      <= org_x;
      cy      <= org_y;
      x_first <= org_x;
      x_last  <= org_x + ext_w - ONE;
      y_last  <= org_y + ext_h - ONE;
    end else if (advance && !last) begin
      if (row_end) begin
        cx <= x_first;
        cy <= cy + ONE;
      end else begin
        cx <= cx + ONE;
      end
    end
  end

endmodule

// File: rtl/rect_plotter.sv
// Rectangle-fill engine: clips a request to the screen and streams one pixel
// write per clock to the VGA adapter, with a full-screen clear mode.
module rect_plotter
  import draw_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               clear,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  input  colour_t            colour_in,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output colour_t            colour,
  output logic               plot
);

  localparam logic [COORD_W-1:0] SW = COORD_W'(SCREEN_W);
  localparam logic [COORD_W-1:0] SH = COORD_W'(SCREEN_H);

  state_t             state, state_nx;
  logic               busy_nx, done_nx, plot_nx;
  logic               accept, empty, last;
  logic [COORD_W-1:0] room_w, room_h;
  logic [COORD_W-1:0] eff_w, eff_h, org_x, org_y;
  logic [COORD_W-1:0] cx, cy;
  colour_t            col_q;

  // Clip against SCREEN-origin rather than origin+extent so large extents cannot wrap.
  always_comb begin
    room_w = SW - x0;
    room_h = SH - y0;
    eff_w  = (x0 >= SW) ? '0 : ((width  < room_w) ? width  : room_w);
    eff_h  = (y0 >= SH) ? '0 : ((height < room_h) ? height : room_h);
    org_x  = x0;
    org_y  = y0;
    if (clear) begin
      org_x = '0;
      org_y = '0;
      eff_w = SW;
      eff_h = SH;
    end
  end

  // A start coinciding with the done pulse is deliberately dropped.
  assign accept = (state == IDLE) && start && !done;
  assign empty  = (eff_w == '0) || (eff_h == '0);

  always_comb begin
    state_nx = state;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    plot_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nx = empty ? FINISH : DRAW;
      end
      DRAW: begin
        busy_nx = 1'b1;
        plot_nx = 1'b1;
        if (last) state_nx = FINISH;
      end
      FINISH: begin
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= BLACK;
    end else begin
      state <= state_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      plot  <= plot_nx;
      if (state == DRAW) begin
        x      <= cx;
        y      <= cy;
        colour <= col_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) col_q <= colour_in;
  end

  raster_counter u_raster (
    .clock   (clock),
    .load    (accept),
    .advance (state == DRAW),
    .org_x   (org_x),
    .org_y   (org_y),
    .ext_w   (eff_w),
    .ext_h   (eff_h),
    .cx      (cx),
    .cy      (cy),
    .last    (last)
  );

endmodule

// File: tb/tb_rect_plotter.sv
// Scoreboard bench for rect_plotter: expected pixel/done events are queued at
// issue time and popped by a negedge monitor whenever plot or done is seen.
module tb_rect_plotter;
  import draw_pkg::*;

  logic               clock  = 1'b0;
  logic               resetn = 1'b0;
  logic               start  = 1'b0;
  logic               clear  = 1'b0;
  logic [COORD_W-1:0] x0     = '0;
  logic [COORD_W-1:0] y0     = '0;
  logic [COORD_W-1:0] width  = '0;
  logic [COORD_W-1:0] height = '0;
  logic [2:0]         colour_in = '0;
  logic               busy, done, plot;
  logic [COORD_W-1:0] x, y;
  logic [2:0]         colour;

  int checks   = 0;
  int failures = 0;
  bit sb_en    = 1'b0;

  typedef struct {
    bit is_done;
    int ex;
    int ey;
    int ec;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  rect_plotter dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .clear     (clear),
    .x0        (x0),
    .y0        (y0),
    .width     (width),
    .height    (height),
    .colour_in (colour_in),
    .busy      (busy),
    .done      (done),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot)
  );

  always #5 clock = ~clock;

  function automatic void chk(string nm, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endfunction

  // Pixel encoded as x*10000 + y*10 + colour for readable diagnostics.
  always @(negedge clock) begin
    if (sb_en && resetn && (plot || done)) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_output", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_kind_done", longint'(done), longint'(mon_e.is_done));
        if (!mon_e.is_done)
          chk("sb_pixel", int'(x) * 10000 + int'(y) * 10 + int'(colour),
              mon_e.ex * 10000 + mon_e.ey * 10 + mon_e.ec);
      end
    end
  end

  task automatic push_px(int px, int py, int pc);
    ev_t e;
    e.is_done = 1'b0;
    e.ex = px;
    e.ey = py;
    e.ec = pc;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    ev_t e;
    e.is_done = 1'b1;
    e.ex = 0;
    e.ey = 0;
    e.ec = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_rect(int ax, int ay, int w, int h, int c);
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++)
        push_px(ax + i, ay + j, c);
    push_done();
  endtask

  // Called #1 after a posedge; returns #1 after edge N (the sampling edge).
  task automatic drive_start(bit clr, int ax, int ay, int aw, int ah, int ac);
    clear     = clr;
    x0        = COORD_W'(ax);
    y0        = COORD_W'(ay);
    width     = COORD_W'(aw);
    height    = COORD_W'(ah);
    colour_in = 3'(ac);
    start     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    clear = 1'b0;
  endtask

  task automatic wait_done(string nm, int exp_cyc, int already);
    int cyc;
    bit seen;
    cyc  = already;
    seen = 1'b0;
    while (!seen && cyc < exp_cyc + 20) begin
      @(posedge clock); #1;
      cyc++;
      if (done) seen = 1'b1;
      else chk({nm, "_busy"}, longint'(busy), longint'(exp_cyc > 1));
    end
    chk({nm, "_done_cycle"}, seen ? cyc : -1, exp_cyc);
    chk({nm, "_busy_at_done"}, longint'(busy), 0);
  endtask

  task automatic idle_gap(string nm);
    @(posedge clock); #1;
    chk({nm, "_done_one_cycle"}, longint'(done), 0);
  endtask

  initial begin
    int act_cnt;

    repeat (2) @(posedge clock);
    #1;
    chk("reset_plot",   longint'(plot),   0);
    chk("reset_busy",   longint'(busy),   0);
    chk("reset_done",   longint'(done),   0);
    chk("reset_x",      longint'(x),      0);
    chk("reset_y",      longint'(y),      0);
    chk("reset_colour", longint'(colour), 0);
    resetn = 1'b1;
    sb_en  = 1'b1;
    @(posedge clock); #1;

    push_px(10, 20, 5); push_px(11, 20, 5);
    push_px(10, 21, 5); push_px(11, 21, 5);
    push_done();
    drive_start(1'b0, 10, 20, 2, 2, 5);
    wait_done("basic", 5, 0);
    idle_gap("basic");

    push_px(158, 119, 3); push_px(159, 119, 3);
    push_done();
    drive_start(1'b0, 158, 119, 4, 4, 3);
    wait_done("clip_corner", 3, 0);
    idle_gap("clip_corner");

    push_done();
    drive_start(1'b0, 200, 10, 5, 5, 1);
    wait_done("clip_offscreen", 1, 0);
    idle_gap("clip_offscreen");

    push_done();
    drive_start(1'b0, 30, 30, 0, 5, 6);
    wait_done("zero_width", 1, 0);
    idle_gap("zero_width");

    // Huge width: clipped to the 60 columns remaining right of x0=100.
    push_rect(100, 7, 60, 1, 7);
    drive_start(1'b0, 100, 7, 2047, 1, 7);
    wait_done("wide_clip", 61, 0);
    idle_gap("wide_clip");

    push_px(5, 5, 3); push_px(6, 5, 3); push_px(7, 5, 3);
    push_done();
    drive_start(1'b0, 5, 5, 3, 1, 3);
    x0        = COORD_W'(50);
    colour_in = 3'd6;
    start     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done("hs_first", 4, 1);

    push_px(1, 2, 2);
    push_done();
    x0        = COORD_W'(1);
    y0        = COORD_W'(2);
    width     = COORD_W'(1);
    height    = COORD_W'(1);
    colour_in = 3'd2;
    start     = 1'b1;
    @(posedge clock); #1;
    chk("hs_done_cycle_busy", longint'(busy), 0);
    @(posedge clock); #1;
    start = 1'b0;
    wait_done("hs_next", 2, 0);
    idle_gap("hs_next");

    push_rect(0, 0, 160, 120, 0);
    drive_start(1'b1, 7, 9, 3, 3, 0);
    wait_done("clear", 19201, 0);
    idle_gap("clear");

    chk("sb_leftover", exp_q.size(), 0);

    sb_en = 1'b0;
    drive_start(1'b0, 30, 40, 10, 10, 4);
    repeat (5) @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    chk("midreset_plot",   longint'(plot),   0);
    chk("midreset_busy",   longint'(busy),   0);
    chk("midreset_done",   longint'(done),   0);
    chk("midreset_x",      longint'(x),      0);
    chk("midreset_y",      longint'(y),      0);
    chk("midreset_colour", longint'(colour), 0);
    @(posedge clock); #1;
    resetn  = 1'b1;
    act_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clock); #1;
      if (plot || done || busy) act_cnt++;
    end
    chk("midreset_no_activity", act_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rect_plotter.md
Name: rect_plotter

Overview:
- Drawing engine directly upstream of the VGA adapter.
- Accepts one rectangle-fill request per handshake and rasterises it into a stream of single-pixel writes, one per clock, on x/y/colour/plot.
- Those outputs connect straight to the adapter's x, y, colour and plot inputs.
- Also provides a full-screen clear, which game logic uses between frames.

Parameters:
- SCREEN_W, 160, visible width in pixels.
- SCREEN_H, 120, visible height in pixels.
- COORD_W, 11, width of every coordinate and extent bus.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- clear  in  1  qualifies start; when 1, the request is the full screen.
- x0  in  COORD_W  rectangle left edge.
- y0  in  COORD_W  rectangle top edge.
- width  in  COORD_W  rectangle width in pixels.
- height  in  COORD_W  rectangle height in pixels.
- colour_in  in  3  fill colour.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the request completes.
- x  out  COORD_W  pixel x to the adapter.
- y  out  COORD_W  pixel y to the adapter.
- colour  out  3  pixel colour to the adapter.
- plot  out  1  pixel-write enable to the adapter.

Behaviour:
- Reset: asynchronous, active-low. While resetn=0, all outputs (busy, done, x, y, colour, plot) are 0 and the FSM is in IDLE.
- A reset mid-draw aborts the request immediately. No further plot pulses occur and no done pulse is issued.
- All outputs are registered.
- FSM states: IDLE, DRAW, FINISH.
- IDLE, start=1 at edge N:
  - Latch the request.
  - Clipping: eff_w = 0 if x0>=SCREEN_W, else min(width, SCREEN_W-x0). eff_h is computed the same way using y0, height and SCREEN_H.
  - clear=1 forces x0=y0=0, eff_w=SCREEN_W, eff_h=SCREEN_H; the width and height inputs are ignored.
  - If eff_w=0 or eff_h=0, go to FINISH and emit no pixels.
  - Otherwise go to DRAW.
- DRAW:
  - Each cycle presents exactly one pixel with plot=1.
  - Raster order: x increments inner, y increments outer.
  - The first pixel (x0,y0) appears at edge N+1. Pixel k (0-based) appears at edge N+1+k.
  - After pixel (x0+eff_w-1, y0+eff_h-1), the next edge enters FINISH with plot=0.
  - Row wrap: when x = x0+eff_w-1, the next pixel is x=x0, y=y+1, in the immediately following cycle with no bubble.
- FINISH: done=1 for exactly one cycle, busy=0 in the same cycle, then return to IDLE.
  - For eff_w*eff_h=P pixels, done is asserted at edge N+1+P.
  - For an empty request, done is asserted at edge N+1.
- busy=1 from edge N+1 through the last DRAW cycle.
- start while busy or in FINISH is ignored; it is not queued.
- start in the same cycle that done pulses is ignored. Back-to-back requests therefore have a minimum one-cycle IDLE gap.
- When plot=0, x, y and colour hold their last values.
- colour output equals the latched colour_in for every pixel of a request; colour_in changes during DRAW have no effect.
- Arithmetic:
  - All coordinate math is done in COORD_W bits.
  - Clip comparisons are unsigned.
  - x0+width overflow is harmless because clipping uses SCREEN_W-x0.
- Throughput: 1 pixel/clock. A full clear takes 19200 plot cycles plus 1 FINISH cycle.

Decomposition:
- Shared package draw_pkg holds:
  - SCREEN_W, SCREEN_H and COORD_W constants.
  - A 3-bit colour typedef.
  - Named colour constants: BLACK=3'b000, WHITE=3'b111.
  - An FSM state enum {IDLE, DRAW, FINISH}.
- One natural sub-module, raster_counter: a nested x/y counter with load (origin, extents), an advance input, and a last-pixel flag. The FSM and clipping logic stay in the top module.

Test Plan:
- Reset: resetn=0 during active DRAW of a 10x10 rectangle -> plot=0, busy=0, x=y=0 immediately; no done pulse after release.
- Basic fill: start at edge N with x0=10, y0=20, width=2, height=2, colour_in=3'b101 -> plot=1 at edges N+1..N+4 with (10,20),(11,20),(10,21),(11,21), colour=3'b101; done at N+5; busy high N+1..N+4.
- Clip: x0=158, y0=119, width=4, height=4 -> exactly 2 pixels, (158,119) and (159,119), then done. A separate request with x0=200 -> zero pixels, done at N+1.
- Zero extent: width=0, height=5 -> no plot; done one cycle after start; busy never asserted.
- Clear: start with clear=1 and colour_in=3'b000 -> 19200 consecutive plot cycles covering (0,0)..(159,119) in raster order, all colour 0; done at N+19201.
- Handshake: a second start mid-draw with different x0 and colour -> ignored; the first rectangle completes unchanged. start asserted on the done cycle -> ignored. start one cycle later -> accepted.
